bsg_sdr_link_downstream_token_ctrl: RTL and testbench
=====================================================

Name: bsg_sdr_link_downstream_token_ctrl

Overview:
- Receive-side counterpart of the SDR link token input.
- Buffers packets arriving from the remote transmitter in core-clock domain, after the link's async FIFO.
- Presents them to the core with a valid/yumi handshake.
- Returns flow-control tokens to the transmitter: one token per 2^lg_credit_to_token_decimation_p dequeued entries.
- One instance per fwd or rev channel per tile.

Parameters:
- width_p, "inv", packet width in bits (fwd_width or rev_width).
- lg_fifo_depth_p, 3, log2 of buffer depth D = 2^lg_fifo_depth_p; equals the transmitter's initial credit count.
- lg_credit_to_token_decimation_p, 2, log2 of credits per token K; must be <= lg_fifo_depth_p (elaboration error otherwise).

Ports:
- core_clk_i  in  1  core clock.
- core_reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  incoming packet valid; no backpressure.
- data_i  in  width_p  incoming packet.
- v_o  out  1  head entry valid.
- data_o  out  width_p  head entry.
- yumi_i  in  1  core consumes head; legal only when v_o=1.
- token_o  out  1  level signal; each toggle is one token returned to the transmitter.
- credits_pending_o  out  lg_credit_to_token_decimation_p+1  dequeues not yet returned as a token (debug).
- overflow_o  out  1  sticky overflow error (see Optional Feature).

Behaviour:
- Reset values: v_o=0, token_o=0, credits_pending_o=0, overflow_o=0, buffer empty. data_o is don't-care while v_o=0.
- Buffer: circular, D entries, read/write pointers of lg_fifo_depth_p bits plus a wrap bit; full/empty derived from the pointers.
- Enqueue:
  - v_i=1 writes data_i at the write pointer.
  - Entry is visible on v_o/data_o the next cycle (1-cycle latency, no bypass).
- Dequeue:
  - yumi_i=1 with v_o=1 advances the read pointer.
  - yumi_i with v_o=0 is ignored; illegal and flagged by assertion.
- Simultaneous enqueue and dequeue: both occur; occupancy is unchanged.
- Full buffer with v_i=1 and yumi_i=1 in the same cycle: accepted (read-before-write semantics).
- Full buffer with v_i=1 and yumi_i=0: packet dropped, pointers unchanged, overflow handling per Optional Feature. This indicates a protocol violation by the transmitter.
- Token counter (width lg_credit_to_token_decimation_p):
  - Increments on each accepted yumi.
  - On reaching K-1 with another yumi, wraps to 0 and token_o toggles in the same registered update; the toggle is visible the next cycle.
  - At most one toggle per cycle.
  - K=1 (decimation 0): every yumi toggles token_o.
- credits_pending_o = counter value; always < K.
- Reset asserted mid-operation:
  - Buffered entries discarded, counter cleared.
  - No token emitted for partial or discarded credits.
  - token_o returns to 0; the transmitter is reset by the same async reset tree and also restarts with D credits.
- Invariant: occupancy + credits_pending + K*(tokens in flight) + transmitter credits = D.

Optional Feature:
- Macro: BSG_SDR_LINK_OVERFLOW_CHECK_EN.
- Defined:
  - A drop sets overflow_o sticky until core_reset_i.
  - A simulation assertion fires with the buffer occupancy.
- Undefined:
  - overflow_o tied 0, no overflow logic.
  - Drop behaviour unchanged (silent drop).

Decomposition:
- Package bsg_sdr_link_pkg holds:
  - a function computing the token counter width from the decimation;
  - a localparam helper for D and K;
  - a parameter legality check used by the elaboration assertion.
- Sub-module bsg_sdr_token_decimator holds the counter plus the toggle register.
  - Inputs: core_clk_i, core_reset_i, credit_v_i.
  - Outputs: token_o, count_o.
  - Reusable by the upstream side for credit accounting.

Test Plan (lg_fifo_depth_p=3 so D=8, decimation=2 so K=4, width_p=16):
- Reset, then single enqueue of 16'hA5A5 at cycle 0 -> v_o=1, data_o=16'hA5A5 at cycle 1; v_o=0 after yumi.
- Enqueue 8 packets, then 4 yumis -> token_o toggles 0->1 exactly once, one cycle after the 4th yumi; credits_pending_o sequence 1,2,3,0.
- Continue to 8 yumis -> second toggle (1->0); buffer empty; ordering preserved (FIFO order on data_o).
- Full buffer (8 entries), v_i=1 with yumi_i=1 same cycle -> new packet accepted, occupancy stays 8, no overflow. Then v_i=1 with yumi_i=0 -> packet dropped; overflow_o=1 with macro defined, 0 without.
- 3 yumis (credits_pending_o=3), then core_reset_i for 1 cycle -> v_o=0, credits_pending_o=0, token_o=0, no toggle; next 4 yumis after refill produce exactly one toggle.
- Random v_i/yumi_i for 10k cycles, constrained so the transmitter model respects credits -> no overflow, toggle count = floor(total yumis / 4), data ordering matches the scoreboard.

Source files
------------

// File: rtl/bsg_sdr_link_pkg.sv
// ----------------------------------------------------------------------------
// bsg_sdr_link_pkg
//
// Shared helpers for the SDR link token logic:
//   token_cnt_width() - storage width of a credit-to-token counter
//   pow2()            - 2^lg, used for buffer depth D and decimation K
//   params_legal()    - parameter legality check used by elaboration asserts
// ----------------------------------------------------------------------------
package bsg_sdr_link_pkg;

  // K = 1 needs no count state, but a zero-width vector is illegal, so keep
  // one bit that simply never leaves zero.
  function automatic int token_cnt_width(input int lg_decimation);
    return (lg_decimation < 1) ? 1 : lg_decimation;
  endfunction

  function automatic int pow2(input int lg);
    return 1 << lg;
  endfunction

  // A token may never represent more credits than the buffer holds.
  function automatic bit params_legal(input int width,
                                      input int lg_depth,
                                      input int lg_decimation);
    return (width >= 1) && (lg_depth >= 1) &&
           (lg_decimation >= 0) && (lg_decimation <= lg_depth);
  endfunction

endpackage

// File: rtl/bsg_sdr_token_decimator.sv
// ----------------------------------------------------------------------------
// bsg_sdr_token_decimator
//
// Counts credit events and toggles token_o once per 2^lg_decimation_p events.
// Shared by the downstream (token return) and upstream (credit accounting)
// sides of the SDR link.
//
// Ports:
//   core_clk_i    in   core clock
//   core_reset_i  in   synchronous active-high reset
//   credit_v_i    in   one credit event this cycle
//   token_o       out  level signal, each toggle is one token
//   count_o       out  credits accumulated toward the next token (< K)
// ----------------------------------------------------------------------------
module bsg_sdr_token_decimator
  import bsg_sdr_link_pkg::*;
#(
  parameter int lg_decimation_p = 2
) (
  input  logic                     core_clk_i,
  input  logic                     core_reset_i,
  input  logic                     credit_v_i,
  output logic                     token_o,
  output logic [lg_decimation_p:0] count_o
);

  localparam int cnt_w_lp = token_cnt_width(lg_decimation_p);
  localparam int k_lp     = pow2(lg_decimation_p);
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(k_lp - 1);

  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                token_q, token_d;

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    token_d = token_q;
    if (credit_v_i) begin
      if (count_q == last_lp) begin
        // Wrap and emit the token in the same registered update.
        count_d = '0;
        token_d = ~token_q;
      end else begin
        count_d = count_q + cnt_w_lp'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      count_q <= '0;
      token_q <= 1'b0;
    end else begin
      count_q <= count_d;
      token_q <= token_d;
    end
  end

  assign token_o = token_q;
  assign count_o = (lg_decimation_p + 1)'(count_q);

endmodule

// File: rtl/bsg_sdr_link_downstream_token_ctrl.sv
// ----------------------------------------------------------------------------
// bsg_sdr_link_downstream_token_ctrl
//
// Receive-side buffer of the SDR link. Packets arriving (after the async FIFO)
// are stored in a D-entry circular buffer and handed to the core over a
// valid/yumi handshake. Every K dequeues one token (a toggle of token_o) is
// returned to the remote transmitter.
//
// Optional feature macro: BSG_SDR_LINK_OVERFLOW_CHECK_EN
//   defined   - a dropped packet sets overflow_o sticky until reset and trips
//               a simulation assertion reporting the occupancy
//   undefined - overflow_o is tied low; drops are silent
//
// Ports:
//   core_clk_i         in   core clock
//   core_reset_i       in   synchronous active-high reset
//   v_i, data_i        in   incoming packet, no backpressure
//   v_o, data_o        out  head entry
//   yumi_i             in   core consumes head (only legal with v_o=1)
//   token_o            out  toggles once per K dequeues
//   credits_pending_o  out  dequeues not yet returned as a token
//   overflow_o         out  sticky drop indicator
// ----------------------------------------------------------------------------
module bsg_sdr_link_downstream_token_ctrl
  import bsg_sdr_link_pkg::*;
#(
  parameter int width_p                         = 0,
  parameter int lg_fifo_depth_p                 = 3,
  parameter int lg_credit_to_token_decimation_p = 2
) (
  input  logic                                     core_clk_i,
  input  logic                                     core_reset_i,
  input  logic                                     v_i,
  input  logic [width_p-1:0]                       data_i,
  output logic                                     v_o,
  output logic [width_p-1:0]                       data_o,
  input  logic                                     yumi_i,
  output logic                                     token_o,
  output logic [lg_credit_to_token_decimation_p:0] credits_pending_o,
  output logic                                     overflow_o
);

  localparam int depth_lp = pow2(lg_fifo_depth_p);
  localparam int ptr_w_lp = lg_fifo_depth_p + 1;

  if (!params_legal(width_p, lg_fifo_depth_p, lg_credit_to_token_decimation_p)) begin : g_param_check
    $error("illegal parameters: width_p=%0d lg_fifo_depth_p=%0d lg_decimation=%0d",
           width_p, lg_fifo_depth_p, lg_credit_to_token_decimation_p);
  end

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [ptr_w_lp-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]        rd_ptr_q, rd_ptr_d;
  logic [lg_fifo_depth_p-1:0] wr_idx, rd_idx;
  logic                       empty, full, enq, deq;
  logic [width_p-1:0]         mem_q [depth_lp];

  always_comb begin
    wr_idx = wr_ptr_q[lg_fifo_depth_p-1:0];
    rd_idx = rd_ptr_q[lg_fifo_depth_p-1:0];
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[lg_fifo_depth_p] != rd_ptr_q[lg_fifo_depth_p]) && (wr_idx == rd_idx);
    deq    = yumi_i & ~empty;
    // A full buffer still accepts when the head leaves this cycle: the head
    // slot is read before the new packet overwrites it at the clock edge.
    enq    = v_i & (~full | deq);
    wr_ptr_d = enq ? wr_ptr_q + ptr_w_lp'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + ptr_w_lp'(1) : rd_ptr_q;
  end

  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge core_clk_i) begin
    if (enq) mem_q[wr_idx] <= data_i;
  end

  assign v_o    = ~empty;
  assign data_o = mem_q[rd_idx];

  bsg_sdr_token_decimator #(
    .lg_decimation_p(lg_credit_to_token_decimation_p)
  ) u_token_decimator (
    .core_clk_i  (core_clk_i),
    .core_reset_i(core_reset_i),
    .credit_v_i  (deq),
    .token_o     (token_o),
    .count_o     (credits_pending_o)
  );

`ifdef BSG_SDR_LINK_OVERFLOW_CHECK_EN
  logic                drop;
  logic                overflow_q, overflow_d;
  logic [ptr_w_lp-1:0] occupancy;

  assign drop       = v_i & full & ~deq;
  assign occupancy  = wr_ptr_q - rd_ptr_q;
  assign overflow_d = overflow_q | drop;

  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) overflow_q <= 1'b0;
    else              overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;

  a_no_overflow: assert property (@(posedge core_clk_i) disable iff (core_reset_i) !drop)
    else $error("transmitter overran receive buffer, occupancy=%0d", occupancy);
`else
  assign overflow_o = 1'b0;
`endif

  a_yumi_legal: assert property (@(posedge core_clk_i) disable iff (core_reset_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o=0");

endmodule

// File: tb/tb_bsg_sdr_link_downstream_token_ctrl.sv
// ----------------------------------------------------------------------------
// Self-checking bench for bsg_sdr_link_downstream_token_ctrl (D=8, K=4, 16b).
// Reference model: a packet queue plus a count of yumis since reset; token
// level and pending credits are derived arithmetically from that count.
// ----------------------------------------------------------------------------
module tb_bsg_sdr_link_downstream_token_ctrl;

  localparam int w_lp = 16;
  localparam int d_lp = 8;
  localparam int k_lp = 4;
`ifdef BSG_SDR_LINK_OVERFLOW_CHECK_EN
  localparam bit ovf_en_lp = 1'b1;
`else
  localparam bit ovf_en_lp = 1'b0;
`endif

  logic            core_clk_i = 1'b0;
  logic            core_reset_i = 1'b0;
  logic            v_i = 1'b0;
  logic [w_lp-1:0] data_i = '0;
  logic            v_o;
  logic [w_lp-1:0] data_o;
  logic            yumi_i = 1'b0;
  logic            token_o;
  logic [2:0]      credits_pending_o;
  logic            overflow_o;

  bsg_sdr_link_downstream_token_ctrl #(
    .width_p                        (w_lp),
    .lg_fifo_depth_p                (3),
    .lg_credit_to_token_decimation_p(2)
  ) dut (
    .core_clk_i       (core_clk_i),
    .core_reset_i     (core_reset_i),
    .v_i              (v_i),
    .data_i           (data_i),
    .v_o              (v_o),
    .data_o           (data_o),
    .yumi_i           (yumi_i),
    .token_o          (token_o),
    .credits_pending_o(credits_pending_o),
    .overflow_o       (overflow_o)
  );

  always #5 core_clk_i = ~core_clk_i;

  int              n_vec = 0;
  int              n_err = 0;
  string           phase = "init";
  logic [w_lp-1:0] model_q[$];
  int              yumis_since_reset = 0;
  int              model_tokens = 0;
  int              dut_toggles = 0;
  bit              prev_tok = 1'b0;
  bit              ovf_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL [%s] %s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, update the model at the edge, then
  // compare every output 1 time unit later.
  task automatic cyc(input bit rst, input bit v, input logic [w_lp-1:0] d, input bit y);
    bit deq;
    core_reset_i = rst;
    v_i          = v;
    data_i       = d;
    yumi_i       = y && (model_q.size() > 0);
    @(posedge core_clk_i);
    if (rst) begin
      model_q.delete();
      yumis_since_reset = 0;
      ovf_exp = 1'b0;
    end else begin
      deq = y && (model_q.size() > 0);
      if (deq) begin
        void'(model_q.pop_front());
        yumis_since_reset++;
        if (yumis_since_reset % k_lp == 0) model_tokens++;
      end
      if (v) begin
        if (model_q.size() < d_lp) model_q.push_back(d);
        else if (ovf_en_lp)        ovf_exp = 1'b1;
      end
    end
    #1;
    check("v_o", 32'(v_o), 32'(model_q.size() > 0));
    if (model_q.size() > 0) check("data_o", 32'(data_o), 32'(model_q[0]));
    check("token_o", 32'(token_o), 32'((yumis_since_reset / k_lp) % 2));
    check("credits_pending_o", 32'(credits_pending_o), 32'(yumis_since_reset % k_lp));
    check("overflow_o", 32'(overflow_o), 32'(ovf_exp));
    if (!rst && (token_o != prev_tok)) dut_toggles++;
    prev_tok     = token_o;
    core_reset_i = 1'b0;
    v_i          = 1'b0;
    yumi_i       = 1'b0;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [w_lp-1:0] base);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, base + w_lp'(i), 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    int tx_credits;
    int tok_before;
    bit v, y;

    phase = "reset";
    do_reset();

    phase = "single";
    cyc(1'b0, 1'b1, 16'hA5A5, 1'b0);
    drain(1);

    phase = "tokens";
    do_reset();
    dut_toggles  = 0;
    model_tokens = 0;
    fill(8, 16'h1000);
    drain(8);
    check("toggles_after_8_yumis", 32'(dut_toggles), 32'd2);

    phase = "full";
    do_reset();
    fill(8, 16'h2000);
    cyc(1'b0, 1'b1, 16'hBEEF, 1'b1);
    cyc(1'b0, 1'b1, 16'hDEAD, 1'b0);
    drain(8);
    check("empty_after_full_drain", 32'(v_o), 32'd0);

    phase = "mid_reset";
    do_reset();
    fill(8, 16'h3000);
    drain(3);
    do_reset();
    dut_toggles  = 0;
    model_tokens = 0;
    fill(4, 16'h4000);
    drain(4);
    check("toggles_after_refill", 32'(dut_toggles), 32'd1);

    phase = "random";
    do_reset();
    dut_toggles  = 0;
    model_tokens = 0;
    tx_credits   = d_lp;
    for (int i = 0; i < 10000; i++) begin
      v = (tx_credits > 0) && ($urandom_range(0, 99) < 60);
      y = $urandom_range(0, 99) < 50;
      tok_before = model_tokens;
      cyc(1'b0, v, w_lp'($urandom), y);
      if (v) tx_credits--;
      if (model_tokens != tok_before) tx_credits += k_lp;
    end
    check("random_toggle_count", 32'(dut_toggles), 32'(model_tokens));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
